// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control FSM and the shared
// instruction/data memory: request, completion, address select and direction.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic IorD;
  logic MemRead;
  logic MemWrite;

  modport master (
    output mem_req,
    output IorD,
    output MemRead,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  IorD,
    input  MemRead,
    input  MemWrite,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM (LDUR/STUR/CBZ/ADD/SUB/AND/ORR) with memory wait timeout.
// Optional performance counters cycle_cnt/instr_cnt are enabled by defining MULTICYCLE_PERF_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
`ifdef MULTICYCLE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  mem,
  input  logic [10:0]        Op,
  input  logic               Zero,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               Reg2Loc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               error,
  output logic [3:0]         state
`ifdef MULTICYCLE_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          ready;
  logic          tmo_hit;
  logic          op_ldur, op_stur, op_cbz, op_rfmt;

  // Gating by reset keeps IRWrite/PCWrite low while the FSM is held in FETCH.
  assign ready   = mem.mem_ready & reset;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_reg == TW'(TIMEOUT - 1)) && !ready;

  assign op_ldur = (Op == 11'b11111000010);
  assign op_stur = (Op == 11'b11111000000);
  assign op_cbz  = (Op[10:3] == 8'b10110100);
  assign op_rfmt = (Op == 11'b10001011000) || (Op == 11'b11001011000) ||
                   (Op == 11'b10001010000) || (Op == 11'b10101010000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      tmo_cnt_reg <= '0;
    end else begin
      // Any exit from a wait state leaves the counter cleared for the next one.
      tmo_cnt_reg <= '0;
      case (state_reg)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (ready) begin
            state_reg <= (state_reg == S_FETCH) ? S_DECODE :
                         (state_reg == S_MEMRD) ? S_MEMWB : S_FETCH;
          end else if (tmo_hit) begin
            state_reg <= S_ERROR;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        S_DECODE: begin
          if (op_ldur || op_stur) state_reg <= S_MEMADR;
          else if (op_cbz)        state_reg <= S_BRANCH;
          else if (op_rfmt)       state_reg <= S_EXEC;
          else                    state_reg <= S_ERROR;
        end
        S_MEMADR: state_reg <= op_ldur ? S_MEMRD : S_MEMWR;
        S_EXEC:   state_reg <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: state_reg <= S_FETCH;
        S_ERROR:  state_reg <= S_ERROR;
        default:  state_reg <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    mem.mem_req  = 1'b0;
    mem.IorD     = 1'b0;
    mem.MemRead  = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    error        = 1'b0;
    Reg2Loc      = (state_reg != S_FETCH) && (state_reg != S_ERROR) && (op_stur || op_cbz);
    case (state_reg)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        mem.MemRead = 1'b1;
        ALUSrcB     = 2'b01;
        IRWrite     = ready;
        PCWrite     = ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.MemRead = 1'b1;
        mem.IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem.mem_req  = 1'b1;
        mem.MemWrite = 1'b1;
        mem.IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
      end
      S_ERROR: error = 1'b1;
      default: error = 1'b1;
    endcase
  end

  assign state = state_reg;

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic             retire;

  assign retire = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) ||
                  (state_reg == S_BRANCH) || ((state_reg == S_MEMWR) && ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (state_reg != S_ERROR) cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (retire)               instr_cnt_reg <= instr_cnt_reg + 1'b1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-cycle expectations are queued by the
// stimulus from an instruction-level model and popped by an independent monitor.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b00000001111;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ERROR = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] Op = '0;
  logic        Zero = 1'b0;
  logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrcA, MemtoReg, RegWrite, error;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  dut_state;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (bus),
    .Op       (Op),
    .Zero     (Zero),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .Reg2Loc  (Reg2Loc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .error    (error),
    .state    (dut_state)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt (cycle_cnt)
    , .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [15:0] outs;
    int          cyc;
    int          ins;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cyc = 0;
  int   m_ins = 0;
  int   n_instr = 0;

  function automatic bit is_cbz(input logic [10:0] o);
    logic [10:0] t;
    t = o;
    return t[10:3] == 8'b10110100;
  endfunction

  function automatic bit is_rfmt(input logic [10:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_ORR);
  endfunction

  // Output vector order: mem_req IorD MemRead MemWrite IRWrite PCWrite PCSrc Reg2Loc
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] MemtoReg RegWrite error
  function automatic logic [15:0] exp_out(input int st, input bit rdy, input bit z, input logic [10:0] o);
    logic mreq, iord, mrd, mwr, irw, pcw, pcs, r2, asa, m2r, rw, err;
    logic [1:0] asb, aop;
    mreq = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; pcs = 0;
    asa = 0; m2r = 0; rw = 0; err = 0; asb = 2'b00; aop = 2'b00;
    r2 = (st != S_FETCH && st != S_ERROR) && ((o == OP_STUR) || is_cbz(o));
    case (st)
      S_FETCH:  begin mreq = 1; mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mreq = 1; mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mreq = 1; mwr = 1; iord = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_ALUWB:  rw = 1;
      S_BRANCH: begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
      default:  err = 1;
    endcase
    return {mreq, iord, mrd, mwr, irw, pcw, pcs, r2, asa, asb, aop, m2r, rw, err};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show, advance.
  task automatic cyc(input int st, input bit rdy, input bit z, input logic [10:0] o);
    exp_t e;
    Op = o;
    Zero = z;
    bus.mem_ready = rdy;
    e.st   = st;
    e.outs = exp_out(st, rdy & reset, z, o);
    e.cyc  = m_cyc;
    e.ins  = m_ins;
    exp_q.push_back(e);
    if (!reset) begin
      m_cyc = 0;
      m_ins = 0;
    end else begin
      if (st != S_ERROR) m_cyc++;
      if (st == S_MEMWB || st == S_ALUWB || st == S_BRANCH || (st == S_MEMWR && rdy)) m_ins++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) cyc(S_FETCH, 1'b1, rnd(), 11'($urandom));
    reset = 1'b1;
  endtask

  // A memory wait phase: `waits` idle cycles then completion, unless the timeout fires first.
  task automatic phase(input int st, input int waits, input logic [10:0] o, output bit err);
    err = 0;
    for (int i = 0; i < waits; i++) begin
      cyc(st, 1'b0, rnd(), o);
      if (i == TO - 1) begin
        err = 1;
        return;
      end
    end
    cyc(st, 1'b1, rnd(), o);
  endtask

  task automatic error_tail(input logic [10:0] o);
    repeat (3) cyc(S_ERROR, rnd(), rnd(), o);
    do_reset(2);
  endtask

  task automatic run_instr(input logic [10:0] o, input int wf, input int wm, input bit z, input bit rst_mid);
    bit err;
    n_instr++;
    $display("instr %0d op=%b fetch_wait=%0d mem_wait=%0d zero=%0d reset_mid=%0d",
             n_instr, o, wf, wm, z, rst_mid);
    phase(S_FETCH, wf, 11'($urandom), err);
    if (err) begin
      error_tail(o);
      return;
    end
    cyc(S_DECODE, rnd(), rnd(), o);
    if (o == OP_LDUR) begin
      cyc(S_MEMADR, rnd(), rnd(), o);
      phase(S_MEMRD, wm, o, err);
      if (!err) cyc(S_MEMWB, rnd(), rnd(), o);
    end else if (o == OP_STUR) begin
      cyc(S_MEMADR, rnd(), rnd(), o);
      if (rst_mid) begin
        cyc(S_MEMWR, 1'b0, rnd(), o);
        do_reset(2);
        return;
      end
      phase(S_MEMWR, wm, o, err);
    end else if (is_cbz(o)) begin
      cyc(S_BRANCH, rnd(), z, o);
    end else if (is_rfmt(o)) begin
      cyc(S_EXEC, rnd(), rnd(), o);
      cyc(S_ALUWB, rnd(), rnd(), o);
    end else begin
      err = 1;
    end
    if (err) error_tail(o);
  endtask

  exp_t        mon_e;
  logic [15:0] mon_act;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_act = {bus.mem_req, bus.IorD, bus.MemRead, bus.MemWrite, IRWrite, PCWrite, PCSrc,
                 Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, MemtoReg, RegWrite, error};
      checks++;
      if (dut_state !== 4'(mon_e.st) || mon_act !== mon_e.outs) begin
        failures++;
        $display("FAIL cycle t=%0t: got state=%0d outs=%h, required state=%0d outs=%h",
                 $time, dut_state, mon_act, mon_e.st, mon_e.outs);
      end
`ifdef MULTICYCLE_PERF_EN
      checks++;
      if (cycle_cnt !== 32'(mon_e.cyc) || instr_cnt !== 32'(mon_e.ins)) begin
        failures++;
        $display("FAIL perf t=%0t: got cycle_cnt=%0d instr_cnt=%0d, required %0d %0d",
                 $time, cycle_cnt, instr_cnt, mon_e.cyc, mon_e.ins);
      end
`endif
    end
  end

  initial begin
    logic [10:0] o;
    int          k;
    int          wf, wm;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(OP_ADD,  0, 0, 1'b0, 1'b0);
    run_instr(OP_STUR, 0, 0, 1'b0, 1'b0);
    run_instr(OP_LDUR, 0, 3, 1'b0, 1'b0);
    run_instr(OP_CBZ,  0, 0, 1'b1, 1'b0);
    run_instr(OP_CBZ,  0, 0, 1'b0, 1'b0);
    run_instr(OP_BAD,  0, 0, 1'b0, 1'b0);
    run_instr(OP_ADD,  TO, 0, 1'b0, 1'b0);
    run_instr(OP_ADD,  TO - 1, 0, 1'b0, 1'b0);
    run_instr(OP_STUR, 1, 0, 1'b0, 1'b1);
    run_instr(OP_LDUR, 0, TO, 1'b0, 1'b0);
    run_instr(OP_STUR, 2, TO - 1, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: o = OP_ADD;
        1: o = OP_SUB;
        2: o = OP_AND;
        3: o = OP_ORR;
        4: o = OP_LDUR;
        5: o = OP_STUR;
        6, 7: o = {8'b10110100, 3'($urandom)};
        default: o = 11'($urandom);
      endcase
      wf = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      wm = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      run_instr(o, wf, wm, rnd(), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
